nmt_context_switch_handler: RTL and testbench

- Consumer end of the rank-predictor `context_switch` pulse.
- When the predictor flags an NMT-write / host-read collision, this block does four things in order:
  - stalls NMT issue;
  - drains the in-flight NMT op;
  - saves the running NMT thread's context;
  - picks the next ready thread round-robin and restores its context.
- Sits between the predictor and the NMT issue pipeline in the near-memory core.

---
 rtl/nmt_context_switch_handler_pkg.sv | 25 ++
 rtl/nmt_context_switch_handler_if.sv | 41 ++++
 rtl/nmt_context_switch_handler_arb.sv | 37 +++
 rtl/nmt_context_switch_handler.sv | 140 ++++++++++++++
 tb/tb_nmt_context_switch_handler.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/nmt_context_switch_handler_pkg.sv
// ---------------------------------------------------------------------------
// nmt_pkg: shared types and constants for the NMT context-switch handler.
//   ctx_sw_state_t   - switch FSM states
//   NMT_NUM_THREADS  - default number of hardware thread contexts
//   NMT_CTX_W        - default width of one saved context word
//   OP_*             - memory op encodings used across the near-memory core
// ---------------------------------------------------------------------------
package nmt_pkg;

    localparam int NMT_NUM_THREADS = 4;
    localparam int NMT_CTX_W       = 32;

    localparam logic [1:0] OP_READ      = 2'd0;
    localparam logic [1:0] OP_WRITE     = 2'd1;
    localparam logic [1:0] OP_NMT_WRITE = 2'd2;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        SAVE,
        SELECT,
        RESTORE
    } ctx_sw_state_t;

endpackage

// File: rtl/nmt_context_switch_handler_if.sv
// ---------------------------------------------------------------------------
// Bus between the rank predictor / NMT pipeline and the switch handler.
//   slave  : handler side (takes requests and pipeline status, drives control)
//   master : environment side
//   context_switch, nmt_busy, cur_ctx, thread_ready -> handler
//   nmt_stall, active_thread, restore_ctx, restore_valid,
//   switch_done, drain_timeout, switch_count       <- handler
// ---------------------------------------------------------------------------
interface nmt_context_switch_handler_if
    import nmt_pkg::*;
#(
    parameter int NUM_THREADS = NMT_NUM_THREADS,
    parameter int CTX_W       = NMT_CTX_W
);
    localparam int IDX_W = $clog2(NUM_THREADS);

    logic                   context_switch;
    logic                   nmt_busy;
    logic [CTX_W-1:0]       cur_ctx;
    logic [NUM_THREADS-1:0] thread_ready;

    logic                   nmt_stall;
    logic [IDX_W-1:0]       active_thread;
    logic [CTX_W-1:0]       restore_ctx;
    logic                   restore_valid;
    logic                   switch_done;
    logic                   drain_timeout;
    logic [15:0]            switch_count;

    modport slave (
        input  context_switch, nmt_busy, cur_ctx, thread_ready,
        output nmt_stall, active_thread, restore_ctx, restore_valid,
               switch_done, drain_timeout, switch_count
    );

    modport master (
        output context_switch, nmt_busy, cur_ctx, thread_ready,
        input  nmt_stall, active_thread, restore_ctx, restore_valid,
               switch_done, drain_timeout, switch_count
    );
endinterface

// File: rtl/nmt_context_switch_handler_arb.sv
// ---------------------------------------------------------------------------
// rr_thread_arbiter: combinational round-robin thread pick.
//   thread_ready_i : runnable mask
//   cur_idx_i      : currently scheduled thread (excluded from the scan)
//   next_idx_o     : first ready thread after cur_idx_i, wrapping; cur_idx_i
//                    if none
//   found_o        : another ready thread was found
// ---------------------------------------------------------------------------
module rr_thread_arbiter
    import nmt_pkg::*;
#(
    parameter int NUM_THREADS = NMT_NUM_THREADS,
    parameter int IDX_W       = $clog2(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0] thread_ready_i,
    input  logic [IDX_W-1:0]       cur_idx_i,
    output logic [IDX_W-1:0]       next_idx_o,
    output logic                   found_o
);
    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest ready thread
    // overwrites the others. NUM_THREADS is a power of 2, so the index add
    // wraps for free.
    always_comb begin
        next_idx_o = cur_idx_i;
        found_o    = 1'b0;
        idx        = '0;
        for (int off = NUM_THREADS - 1; off >= 1; off--) begin
            idx = cur_idx_i + IDX_W'(off);
            if (thread_ready_i[idx]) begin
                next_idx_o = idx;
                found_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/nmt_context_switch_handler.sv
// ---------------------------------------------------------------------------
// nmt_context_switch_handler: on a predictor context_switch pulse, stalls NMT
// issue, drains the in-flight op (with timeout), saves the running thread's
// context, picks the next ready thread round-robin and restores its context.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of nmt_context_switch_handler_if (see that file)
// All outputs are registered.
// ---------------------------------------------------------------------------
module nmt_context_switch_handler
    import nmt_pkg::*;
#(
    parameter int NUM_THREADS   = NMT_NUM_THREADS,
    parameter int CTX_W         = NMT_CTX_W,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    nmt_context_switch_handler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_THREADS);
    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);

    ctx_sw_state_t                      state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [NUM_THREADS-1:0][CTX_W-1:0]  mem_q, mem_d;
    logic                               stall_q, stall_d;
    logic [IDX_W-1:0]                   active_q, active_d;
    logic [CTX_W-1:0]                   rctx_q, rctx_d;
    logic                               rvalid_q, rvalid_d;
    logic                               done_q, done_d;
    logic                               tmo_q, tmo_d;
    logic [15:0]                        count_q, count_d;

    logic [IDX_W-1:0]                   arb_next;
    logic                               arb_found;

    rr_thread_arbiter #(
        .NUM_THREADS (NUM_THREADS),
        .IDX_W       (IDX_W)
    ) u_arb (
        .thread_ready_i (bus.thread_ready),
        .cur_idx_i      (active_q),
        .next_idx_o     (arb_next),
        .found_o        (arb_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            mem_q    <= '0;
            stall_q  <= 1'b0;
            active_q <= '0;
            rctx_q   <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            stall_q  <= stall_d;
            active_q <= active_d;
            rctx_q   <= rctx_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        stall_d  = stall_q;
        active_d = active_q;
        rctx_d   = rctx_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        tmo_d    = 1'b0;
        count_d  = count_q;

        case (state_q)
            RUN: begin
                if (bus.context_switch) begin
                    state_d = DRAIN;
                    stall_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (!bus.nmt_busy) begin
                    state_d = SAVE;
                end else if (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                    // Last allowed drain cycle still busy: abort, no save.
                    state_d = RUN;
                    stall_d = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAVE: begin
                mem_d[active_q] = bus.cur_ctx;
                state_d         = SELECT;
            end
            SELECT: begin
                // Results are registered here so they are visible during
                // RESTORE; the memory already holds this cycle's save, so a
                // no-op switch reloads the just-saved context.
                active_d = arb_next;
                rctx_d   = mem_q[arb_next];
                rvalid_d = 1'b1;
                done_d   = 1'b1;
                if (arb_found && count_q != 16'hFFFF)
                    count_d = count_q + 16'd1;
                state_d  = RESTORE;
            end
            RESTORE: begin
                state_d = RUN;
                stall_d = 1'b0;
            end
            default: begin
                state_d = RUN;
                stall_d = 1'b0;
            end
        endcase
    end

    assign bus.nmt_stall     = stall_q;
    assign bus.active_thread = active_q;
    assign bus.restore_ctx   = rctx_q;
    assign bus.restore_valid = rvalid_q;
    assign bus.switch_done   = done_q;
    assign bus.drain_timeout = tmo_q;
    assign bus.switch_count  = count_q;

endmodule

// File: tb/tb_nmt_context_switch_handler.sv
// ---------------------------------------------------------------------------
// Self-checking bench for nmt_context_switch_handler (4 threads, 32-bit ctx,
// drain timeout 16). A transaction-level model predicts, per switch request,
// the cycle each pulse appears and the resulting thread / context / count.
// ---------------------------------------------------------------------------
module tb_nmt_context_switch_handler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nmt_context_switch_handler_if #(.NUM_THREADS(4), .CTX_W(32)) bus();

    nmt_context_switch_handler #(
        .NUM_THREADS   (4),
        .CTX_W         (32),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [31:0] ref_mem [4];
    int          ref_active;
    int          ref_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_pick(input int cur, input logic [3:0] rdy);
        for (int off = 1; off < 4; off++)
            if (rdy[(cur + off) % 4]) return (cur + off) % 4;
        return cur;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'd0;
        ref_active = 0;
        ref_count  = 0;
    endtask

    // One switch request issued at relative edge 0. busy_n: nmt_busy is high
    // at edges 0..busy_n-1. dup_at: edge of an extra (ignored) pulse, -1 none.
    // thread_ready and cur_ctx are scrambled except at the edge where each is
    // supposed to be sampled.
    task automatic run_switch(input int busy_n, input logic [3:0] rdy,
                              input logic [31:0] ctx, input int dup_at);
        int b, sel_e, save_e, end_e, nxt;
        bit tmo;
        logic [31:0] exp_ctx;
        b      = (busy_n > 1) ? busy_n - 1 : 0;   // busy samples seen in DRAIN
        tmo    = (b >= 16);
        save_e = b + 2;
        sel_e  = b + 3;
        end_e  = tmo ? 16 : b + 4;
        exp_ctx = 32'd0;
        if (!tmo) begin
            ref_mem[ref_active] = ctx;
            nxt = ref_pick(ref_active, rdy);
            exp_ctx = ref_mem[nxt];
            if (nxt != ref_active && ref_count < 16'hFFFF) ref_count++;
            ref_active = nxt;
        end

        bus.context_switch = 1'b1;
        bus.nmt_busy       = (busy_n > 0);
        bus.thread_ready   = 4'($urandom);
        bus.cur_ctx        = $urandom;
        for (int k = 0; k <= end_e + 1; k++) begin
            step();
            bus.context_switch = (k + 1 == dup_at);
            bus.nmt_busy       = (k + 1 < busy_n);
            bus.thread_ready   = (k + 1 == sel_e) ? rdy : 4'($urandom);
            bus.cur_ctx        = (k + 1 == save_e) ? ctx : $urandom;
            chk("stall", 32'(bus.nmt_stall), 32'(k < end_e));
            chk("done", 32'(bus.switch_done), 32'(!tmo && k == sel_e));
            chk("rvalid", 32'(bus.restore_valid), 32'(!tmo && k == sel_e));
            chk("timeout", 32'(bus.drain_timeout), 32'(tmo && k == 16));
            if (!tmo && k == sel_e) begin
                chk("active", 32'(bus.active_thread), 32'(ref_active));
                chk("rctx", bus.restore_ctx, exp_ctx);
                chk("count", 32'(bus.switch_count), 32'(ref_count));
            end
            if (tmo && k == 16) begin
                chk("tmo_active", 32'(bus.active_thread), 32'(ref_active));
                chk("tmo_count", 32'(bus.switch_count), 32'(ref_count));
            end
        end
        bus.context_switch = 1'b0;
        bus.nmt_busy       = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(bus.nmt_stall), 32'd0);
        chk({tag, "_active"}, 32'(bus.active_thread), 32'd0);
        chk({tag, "_rctx"}, bus.restore_ctx, 32'd0);
        chk({tag, "_rvalid"}, 32'(bus.restore_valid), 32'd0);
        chk({tag, "_done"}, 32'(bus.switch_done), 32'd0);
        chk({tag, "_tmo"}, 32'(bus.drain_timeout), 32'd0);
        chk({tag, "_count"}, 32'(bus.switch_count), 32'd0);
    endtask

    initial begin
        int bn, dup;
        rst = 1'b1;
        bus.context_switch = 1'b0;
        bus.nmt_busy       = 1'b0;
        bus.cur_ctx        = 32'd0;
        bus.thread_ready   = 4'd0;
        ref_reset();
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Wrap and restore: 0 -> 3 saving 12345678 into thread 0, then 3 -> 0.
        run_switch(0, 4'b1000, 32'h1234_5678, -1);
        run_switch(0, 4'b0001, 32'hDEAD_0003, -1);
        // Basic switch from thread 0 with ready 0110 -> thread 1, ctx 0.
        run_switch(0, 4'b0110, 32'hA5A5_0000, -1);
        // Drain wait: busy for 5 cycles starting with the pulse.
        run_switch(5, 4'b1111, 32'h0BAD_F00D, -1);
        // Timeout: busy stuck.
        run_switch(20, 4'b1111, 32'h5555_AAAA, -1);
        // No-op switch: nothing ready, own context comes back.
        run_switch(2, 4'b0000, 32'hC0FF_EE00, -1);
        // Second pulse during DRAIN is ignored.
        run_switch(3, 4'b1111, 32'h7777_1111, 2);

        // Randomized requests.
        repeat (25) begin
            bn  = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 19)
                                              : $urandom_range(0, 6);
            dup = ($urandom_range(0, 1) == 1) ? 1 + $urandom_range(0, 2) : -1;
            run_switch(bn, 4'($urandom), $urandom, dup);
        end

        // Reset while in SELECT abandons the switch.
        bus.context_switch = 1'b1;
        step();                     // DRAIN
        bus.context_switch = 1'b0;
        step();                     // SAVE
        step();                     // SELECT
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        ref_reset();
        rst = 1'b0;
        repeat (4) begin
            step();
            chk("post_rst_done", 32'(bus.switch_done), 32'd0);
        end
        // Context memory was cleared: thread 1 restores 0.
        run_switch(0, 4'b0010, 32'h9999_9999, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
